decoder_scan_sequencer: RTL and testbench

Registered sequencer that generates the 3-bit select code (a2,a1,a0) driving the 3-to-8 decoder stage, plus an enable qualifying the decoder outputs. It steps through all eight codes, up or down, holding each code for a programmable number of cycles, in single-pass or continuous mode, under a start/stop pulse interface. It is the stage directly upstream of the decoder.

---
 rtl/decoder_scan_sequencer.sv | 177 +++++++++++++++++
 tb/tb_decoder_scan_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/decoder_scan_sequencer.sv
// decoder_scan_sequencer
// Generates the 3-bit select code {a2,a1,a0} and the qualifying enable for the
// downstream 3-to-8 decoder. The code walks all eight values up or down, each
// held for dwell+1 cycles, either once (single pass, ends with done) or
// continuously (wrap pulse on every wrap-around). All outputs are registered.

module decoder_scan_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               dir,
    input  logic               single,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a2,
    output logic               a1,
    output logic               a0,
    output logic               en,
    output logic               busy,
    output logic               wrap,
    output logic               done
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e             state_q;
    logic [2:0]         code_q;
    logic [DWELL_W-1:0] cnt_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               dir_q;
    logic               single_q;
    logic               en_q;
    logic               busy_q;
    logic               wrap_q;
    logic               done_q;

    logic               dwell_end_d;
    logic               terminal_d;
    logic [2:0]         code_step_d;
    logic [DWELL_W-1:0] cnt_inc_d;

    // Next code in the scan direction; modulo-8 arithmetic gives the wrap for free.
    function automatic logic [2:0] step_code(input logic [2:0] c, input logic down);
        logic [2:0] r;
        if (down) begin
            r = c - 3'd1;
        end else begin
            r = c + 3'd1;
        end
        return r;
    endfunction

    // Last code of a pass: 111 when counting up, 000 when counting down.
    function automatic logic is_terminal(input logic [2:0] c, input logic down);
        logic r;
        if (down) begin
            r = (c == 3'b000);
        end else begin
            r = (c == 3'b111);
        end
        return r;
    endfunction

    // First code of a pass: 000 when counting up, 111 when counting down.
    function automatic logic [2:0] first_code(input logic down);
        logic [2:0] r;
        if (down) begin
            r = 3'b111;
        end else begin
            r = 3'b000;
        end
        return r;
    endfunction

    // Per-cycle decisions derived from the current code and dwell count.
    always_comb begin
        dwell_end_d = 1'b0;
        terminal_d  = 1'b0;
        code_step_d = 3'b000;
        cnt_inc_d   = {DWELL_W{1'b0}};
        if (cnt_q >= dwell_q) begin
            dwell_end_d = 1'b1;
        end else begin
            dwell_end_d = 1'b0;
        end
        terminal_d  = is_terminal(code_q, dir_q);
        code_step_d = step_code(code_q, dir_q);
        cnt_inc_d   = cnt_q + DWELL_W'(1);
    end

    // Sequencer FSM: state, code, dwell counter, latched controls and output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            code_q   <= 3'b000;
            cnt_q    <= {DWELL_W{1'b0}};
            dwell_q  <= {DWELL_W{1'b0}};
            dir_q    <= 1'b0;
            single_q <= 1'b0;
            en_q     <= 1'b0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {DWELL_W{1'b0}};
                    if (start && !stop) begin
                        state_q  <= ST_RUN;
                        dir_q    <= dir;
                        single_q <= single;
                        dwell_q  <= dwell;
                        code_q   <= first_code(dir);
                        en_q     <= 1'b1;
                        busy_q   <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                        code_q  <= 3'b000;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Abort: drop straight to idle without any pulse.
                        state_q <= ST_IDLE;
                        code_q  <= 3'b000;
                        cnt_q   <= {DWELL_W{1'b0}};
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (!dwell_end_d) begin
                        cnt_q <= cnt_inc_d;
                    end else if (!terminal_d) begin
                        code_q <= code_step_d;
                        cnt_q  <= {DWELL_W{1'b0}};
                    end else if (!single_q) begin
                        // Continuous mode: wrap and flag the first cycle of the new pass.
                        code_q <= code_step_d;
                        cnt_q  <= {DWELL_W{1'b0}};
                        wrap_q <= 1'b1;
                    end else begin
                        // Single pass finished.
                        state_q <= ST_IDLE;
                        code_q  <= 3'b000;
                        cnt_q   <= {DWELL_W{1'b0}};
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    code_q  <= 3'b000;
                    cnt_q   <= {DWELL_W{1'b0}};
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign a2   = code_q[2];
    assign a1   = code_q[1];
    assign a0   = code_q[0];
    assign en   = en_q;
    assign busy = busy_q;
    assign wrap = wrap_q;
    assign done = done_q;

endmodule

// File: tb/tb_decoder_scan_sequencer.sv
// Testbench for decoder_scan_sequencer: a stimulus process drives inputs on the
// falling edge and pushes the expected registered outputs into a queue; a
// monitor pops and compares shortly after each rising edge.

module tb_decoder_scan_sequencer;

    localparam int DW = 4;

    logic          clk     = 1'b0;
    logic          clk_run = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          dir     = 1'b0;
    logic          single  = 1'b0;
    logic [DW-1:0] dwell   = '0;
    logic          a2, a1, a0, en, busy, wrap, done;

    decoder_scan_sequencer #(.DWELL_W(DW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .dir    (dir),
        .single (single),
        .dwell  (dwell),
        .a2     (a2),
        .a1     (a1),
        .a0     (a0),
        .en     (en),
        .busy   (busy),
        .wrap   (wrap),
        .done   (done)
    );

    // Clock generator, held low until the reset-only check is done.
    always #5 if (clk_run) clk = ~clk;

    int         n_vec = 0;
    int         n_err = 0;
    logic [6:0] sb_q[$];

    // Reference model: elapsed cycles since start, plus latched controls.
    bit         m_run    = 1'b0;
    int         m_k      = 0;
    bit         m_dir    = 1'b0;
    bit         m_single = 1'b0;
    int         m_dw     = 0;
    logic [6:0] cur_exp  = 7'd0;

    // {code[2:0], en, busy, wrap, done}
    function automatic logic [6:0] pack(input logic [2:0] c, input bit e, input bit b,
                                        input bit w, input bit d);
        return {c, e, b, w, d};
    endfunction

    // Code visible during the given step of a scan.
    function automatic logic [2:0] code_at(input int stp, input bit down);
        int s;
        s = stp % 8;
        if (down) return 3'(7 - s);
        return 3'(s);
    endfunction

    function automatic logic [6:0] dut_out();
        return {a2, a1, a0, en, busy, wrap, done};
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got code=%b en=%b busy=%b wrap=%b done=%b, want code=%b en=%b busy=%b wrap=%b done=%b @%0t",
                     name, act[6:4], act[3], act[2], act[1], act[0],
                     exp[6:4], exp[3], exp[2], exp[1], exp[0], $time);
        end
    endtask

    // One cycle of stimulus; the model computes what must be visible after the next edge.
    task automatic step(input bit st, input bit sp, input bit dr, input bit sg, input int dwv);
        logic [6:0] e;
        int         per;
        int         stp;
        @(negedge clk);
        start  = st;
        stop   = sp;
        dir    = dr;
        single = sg;
        dwell  = DW'(dwv);
        if (!m_run) begin
            if (st && !sp) begin
                m_run    = 1'b1;
                m_k      = 0;
                m_dir    = dr;
                m_single = sg;
                m_dw     = dwv;
                e = pack(code_at(0, dr), 1'b1, 1'b1, 1'b0, 1'b0);
            end else begin
                e = pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
            end
        end else if (sp) begin
            m_run = 1'b0;
            e = pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
        end else begin
            m_k++;
            per = m_dw + 1;
            stp = m_k / per;
            if (m_single && m_k == 8 * per) begin
                m_run = 1'b0;
                e = pack(3'b000, 1'b0, 1'b0, 1'b0, 1'b1);
            end else begin
                e = pack(code_at(stp, m_dir), 1'b1, 1'b1,
                         (!m_single && (m_k % per == 0) && (stp % 8 == 0)), 1'b0);
            end
        end
        sb_q.push_back(e);
        cur_exp = e;
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 0);
    endtask

    // Asynchronous reset between edges; outputs must clear before the next edge.
    task automatic async_reset();
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1 check("async_reset", dut_out(), 7'd0);
        m_run   = 1'b0;
        start   = 1'b0;
        stop    = 1'b0;
        cur_exp = 7'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: compare every presented output against the oldest expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() != 0) begin
                check("cycle", dut_out(), sb_q.pop_front());
            end
        end
    end

    initial begin
        bit hit;
        // Reset with no clock running.
        #2 rst_n = 1'b0;
        #1 check("reset_noclk", dut_out(), 7'd0);
        clk_run = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_steps(2);

        // Single pass up, dwell 0.
        step(1'b1, 1'b0, 1'b0, 1'b1, 0);
        idle_steps(10);

        // Continuous down, dwell 2, with ignored junk on start/dir/single/dwell.
        step(1'b1, 1'b0, 1'b1, 1'b0, 2);
        for (int i = 0; i < 60; i++)
            step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
        step(1'b0, 1'b1, 1'b0, 1'b0, 0);
        idle_steps(2);

        // Continuous up, dwell 3: stop while code is 101.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (cur_exp[6:4] == 3'd5) begin
                step(1'b0, 1'b1, 1'b0, 1'b0, 0);
                hit = 1'b1;
            end else begin
                step(1'b0, 1'b0, 1'b0, 1'b0, 0);
            end
        end
        idle_steps(3);

        // start and stop together in idle: stop wins.
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 2);
        idle_steps(1);

        // Async reset mid-dwell at code 011, then no restart without a new start.
        step(1'b1, 1'b0, 1'b0, 1'b0, 3);
        hit = 1'b0;
        for (int i = 0; i < 40 && !hit; i++) begin
            if (cur_exp[6:4] == 3'd3 && (m_k % 4) == 1) hit = 1'b1;
            else step(1'b0, 1'b0, 1'b0, 1'b0, 0);
        end
        async_reset();
        idle_steps(5);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1);
        idle_steps(20);

        // Randomized traffic.
        for (int i = 0; i < 800; i++)
            step(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 24) == 0),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)));
        idle_steps(2);

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
